// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset control FSM.
// Covers state encodings, opcodes, mux select codes and the control word layout.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

  // States whose exit edge marks an instruction as complete.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTYPEWB) ||
           (s == S_ADDIWB) || (s == S_BEQ) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Moore decode of the FSM state into the datapath control word.
module multicycle_control_decode
  import multicycle_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  // Per-state control word; anything not named for a state stays 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_BEQ: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: state register,
// next-state logic, retired-instruction counter and reset-gated control outputs.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount,
  output logic             IllegalOp
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  ctrl_t            w_ctrl;

  // Next-state selection; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if ((Op == OP_LW) || (Op == OP_SW)) begin
          w_next = S_MEMADR;
        end else if (Op == OP_RTYPE) begin
          w_next = S_EXEC;
        end else if (Op == OP_BEQ) begin
          w_next = S_BEQ;
        end else if (Op == OP_ADDI) begin
          w_next = S_ADDIEX;
        end else if (Op == OP_J) begin
          w_next = S_JUMP;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (Op == OP_LW) begin
          w_next = S_MEMRD;
        end else begin
          w_next = S_MEMWR;
        end
      end
      S_MEMRD:   w_next = S_MEMWB;
      S_EXEC:    w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // State register and retirement counter; counter wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (is_retire_state(r_state)) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  multicycle_control_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Gate every enable with reset so the PC and IR cannot load while held in reset.
  assign PCWrite     = w_ctrl.pc_write      & ~reset;
  assign PCWriteCond = w_ctrl.pc_write_cond & ~reset;
  assign IorD        = w_ctrl.i_or_d        & ~reset;
  assign MemRead     = w_ctrl.mem_read      & ~reset;
  assign MemWrite    = w_ctrl.mem_write     & ~reset;
  assign IRWrite     = w_ctrl.ir_write      & ~reset;
  assign MemtoReg    = w_ctrl.mem_to_reg    & ~reset;
  assign RegDst      = w_ctrl.reg_dst       & ~reset;
  assign RegWrite    = w_ctrl.reg_write     & ~reset;
  assign ALUSrcA     = w_ctrl.alu_src_a     & ~reset;
  assign ALUSrcB     = reset ? 2'b00 : w_ctrl.alu_src_b;
  assign ALUOp       = reset ? 2'b00 : w_ctrl.alu_op;
  assign PCSource    = reset ? 2'b00 : w_ctrl.pc_source;
  assign State       = r_state;
  assign InstrCount  = reset ? '0 : r_count;
  assign IllegalOp   = ~reset & (r_state == S_DECODE) & ~op_supported(Op);

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS-subset processor. It sits beside the datapath and consumes the opcode latched in the instruction register. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It also exports the current state and a retired-instruction counter, which the bench's signal-display task reads.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- Op, input, 6, opcode bits [31:26] of the instruction register.
- PCWrite, output, 1, unconditional PC load.
- PCWriteCond, output, 1, PC load qualified by ALU Zero in the datapath (beq).
- IorD, output, 1, memory address select: 0 = PC, 1 = ALUOut.
- MemRead, output, 1, memory read strobe.
- MemWrite, output, 1, memory write strobe.
- IRWrite, output, 1, instruction register load.
- MemtoReg, output, 1, register writeback select: 0 = ALUOut, 1 = MDR.
- RegDst, output, 1, destination register select: 0 = rt, 1 = rd.
- RegWrite, output, 1, register file write.
- ALUSrcA, output, 1, ALU operand A select: 0 = PC, 1 = register A.
- ALUSrcB, output, 2, ALU operand B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp, output, 2, ALU operation: 00 = add, 01 = sub, 10 = decode by funct.
- PCSource, output, 2, next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- State, output, 4, current state encoding.
- InstrCount, output, CNT_W, count of completed instructions.
- IllegalOp, output, 1, one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5.
  - EXEC 6, RTYPEWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by Op: lw or sw -> MEMADR; R-type -> EXEC; beq -> BEQ; addi -> ADDIEX; j -> JUMP.
  - DECODE with any other Op -> FETCH, and IllegalOp = 1 for that cycle.
  - MEMADR -> MEMRD if Op = lw, else MEMWR.
  - MEMRD -> MEMWB -> FETCH. MEMWR -> FETCH.
  - EXEC -> RTYPEWB -> FETCH. ADDIEX -> ADDIWB -> FETCH. BEQ -> FETCH. JUMP -> FETCH.
- Outputs are a pure Moore decode of State. Every output not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite = 1; ALUSrcB = 01.
  - DECODE: ALUSrcB = 11.
  - MEMADR and ADDIEX: ALUSrcA = 1; ALUSrcB = 10.
  - MEMRD: MemRead, IorD = 1.
  - MEMWR: MemWrite, IorD = 1.
  - MEMWB: RegWrite, MemtoReg = 1.
  - EXEC: ALUSrcA = 1; ALUOp = 10.
  - RTYPEWB: RegWrite, RegDst = 1.
  - ADDIWB: RegWrite = 1.
  - BEQ: ALUSrcA, PCWriteCond = 1; ALUOp = 01; PCSource = 01.
  - JUMP: PCWrite = 1; PCSource = 10.
- Retirement: InstrCount increments by 1 on the edge leaving MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQ or JUMP. An illegal opcode does not count.
- InstrCount wraps from all-ones to 0.
- Op is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite is 0 outside FETCH.

## Timing
- Reset is asynchronous: State goes to FETCH and InstrCount to 0 immediately.
- While reset = 1, all outputs except State are forced to 0, gated combinationally by reset. This keeps the PC and IR from loading during reset.
- After reset is released, the first rising edge completes FETCH.
- Cycles per instruction: lw 5; sw, R-type and addi 4; beq and j 3; illegal 2.
- All transitions take effect on the rising clk edge. Outputs settle combinationally from State within the same cycle.
- Reset asserted mid-instruction aborts it: no retirement and no pending write.
- IllegalOp is combinational and high only during the DECODE cycle that holds the illegal Op.

## Structure
- Shared package `multicycle_pkg` holds:
  - state localparams;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - ALUSrcB and PCSource select codes.
- One natural sub-module, `multicycle_control_decode`: combinational State-to-control-word decoder, instantiated by this block. The state register, next-state logic and counter stay at the top level.

## Test plan
- Reset: hold reset for 3 cycles, then release. State = 0, InstrCount = 0 and all enables = 0 during reset. The first post-reset cycle shows MemRead = IRWrite = PCWrite = 1 and ALUSrcB = 01.
- Op = 100011 (lw): states 0, 1, 2, 3, 4, 0. RegWrite = MemtoReg = 1 only in state 4. InstrCount goes 0 -> 1 after 5 cycles.
- Op = 101011, then 000000, then 001000: sequences 0,1,2,5 / 0,1,6,7 / 0,1,9,10. InstrCount = 3 after 12 cycles. MemWrite is high exactly once.
- Op = 000100 then 000010: BEQ asserts PCWriteCond = 1 with PCSource = 01. JUMP asserts PCWrite = 1 with PCSource = 10. Each takes 3 cycles.
- Op = 111111: DECODE pulses IllegalOp = 1 and returns to FETCH after 2 cycles. InstrCount is unchanged.
- Assert reset during MEMRD of an lw: state goes to 0 asynchronously before the next edge. No MEMWB occurs and InstrCount is not incremented.
